// File: rtl/mem_to_reg_pkg.sv
// Default register-bus request/response types for the mem_to_reg bridge.
// Integrators may substitute their own structs that have the same field names.
`timescale 1ns/1ps
package mem_to_reg_pkg;

  localparam int unsigned REG_AW = 32;
  localparam int unsigned REG_DW = 32;

  typedef struct packed {
    logic                  valid;
    logic                  write;
    logic [REG_AW-1:0]     addr;
    logic [REG_DW-1:0]     wdata;
    logic [REG_DW/8-1:0]   wstrb;
  } reg_req_t;

  typedef struct packed {
    logic                  ready;
    logic [REG_DW-1:0]     rdata;
    logic                  error;
  } reg_rsp_t;

  // A response pulse is produced for every read, and for writes only when enabled.
  function automatic logic resp_enable(input logic write, input logic wr_rsp);
    return ~write | wr_rsp;
  endfunction

endpackage

// File: rtl/mem_to_reg.sv
// Bridge from an SRAM-style req/gnt/rvalid initiator to the valid/ready register bus.
// At most one transaction is in flight; the request is fully registered before it reaches the bus.
`timescale 1ns/1ps
module mem_to_reg
  import mem_to_reg_pkg::*;
#(
  parameter int unsigned AW    = 16,
  parameter int unsigned DW    = 32,
  parameter type         req_t = reg_req_t,
  parameter type         rsp_t = reg_rsp_t,
  parameter bit          WrRsp = 1'b0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_i,
  output logic          gnt_o,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [DW/8-1:0] wstrb_i,
  output logic [DW-1:0] rdata_o,
  output logic          rvalid_o,
  output logic          rerror_o,
  output logic          wr_err_o,
  input  logic          wr_err_clr_i,
  output req_t          reg_req_o,
  input  rsp_t          reg_rsp_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  req_t reg_req_d;

  localparam int unsigned RegAw = $bits(reg_req_d.addr);
  localparam int unsigned RegDw = $bits(reg_req_d.wdata);

  if (AW > RegAw) begin : g_aw_too_wide
    $error("mem_to_reg: AW exceeds register bus address width");
  end
  if (DW != RegDw) begin : g_dw_mismatch
    $error("mem_to_reg: DW must equal register bus data width");
  end
  if ((DW % 8) != 0) begin : g_dw_not_bytes
    $error("mem_to_reg: DW must be a multiple of 8");
  end

  state_e            state_q, state_d;
  logic              write_q;
  logic [AW-1:0]     addr_q;
  logic [DW-1:0]     wdata_q;
  logic [DW/8-1:0]   wstrb_q;
  logic [DW-1:0]     rdata_q;
  logic              error_q;
  logic              resp_en_q;
  logic              wr_err_q;

  logic              accept;
  logic              rsp_take;
  logic              wr_err_set;

  assign accept     = req_i & gnt_o;
  assign rsp_take   = (state_q == BUSY) & reg_rsp_i.ready;
  assign wr_err_set = rsp_take & write_q & reg_rsp_i.error & ~WrRsp;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; ready outside BUSY has no effect
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: state_d = req_i ? BUSY : IDLE;
      BUSY:       state_d = reg_rsp_i.ready ? DONE : BUSY;
      default:    state_d = IDLE;
    endcase
  end

  // Output decode: grant and bus valid depend on state only, never on reg_rsp_i
  always_comb begin
    gnt_o              = (state_q != BUSY);
    rvalid_o           = (state_q == DONE) & resp_en_q;
    reg_req_d          = '0;
    reg_req_d.valid    = (state_q == BUSY);
    reg_req_d.write    = write_q;
    reg_req_d.addr[AW-1:0] = addr_q;
    reg_req_d.wdata    = wdata_q;
    reg_req_d.wstrb    = wstrb_q;
  end

  assign reg_req_o = reg_req_d;

  // Request capture on grant
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (accept) begin
      write_q <= we_i;
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
      wstrb_q <= wstrb_i;
    end
  end

  // Response capture on ready; write responses carry zero data
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q   <= '0;
      error_q   <= 1'b0;
      resp_en_q <= 1'b0;
    end else if (rsp_take) begin
      rdata_q   <= write_q ? '0 : reg_rsp_i.rdata;
      error_q   <= reg_rsp_i.error;
      resp_en_q <= resp_enable(write_q, WrRsp);
    end
  end

  // Sticky write-error flag; a new error outranks a simultaneous clear
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_err_q <= 1'b0;
    end else if (wr_err_set) begin
      wr_err_q <= 1'b1;
    end else if (wr_err_clr_i) begin
      wr_err_q <= 1'b0;
    end
  end

  assign rdata_o  = rdata_q;
  assign rerror_o = error_q;
  assign wr_err_o = wr_err_q;

endmodule

// File: tb/tb_mem_to_reg.sv
// Self-checking bench for mem_to_reg: two instances (write responses off/on) share one stimulus stream.
`timescale 1ns/1ps
module tb_mem_to_reg;
  import mem_to_reg_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we, clr;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  reg_rsp_t    rsp;
  reg_req_t    rq0, rq1;
  logic        gnt0, gnt1, rv0, rv1, re0, re1, werr0, werr1;
  logic [31:0] rd0, rd1;

  int   checks = 0;
  int   errors = 0;
  logic wr_err_exp;

  always #5 clk = ~clk;

  mem_to_reg #(.AW(16), .DW(32), .req_t(reg_req_t), .rsp_t(reg_rsp_t), .WrRsp(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt0), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .wstrb_i(wstrb), .rdata_o(rd0), .rvalid_o(rv0), .rerror_o(re0),
    .wr_err_o(werr0), .wr_err_clr_i(clr), .reg_req_o(rq0), .reg_rsp_i(rsp)
  );

  mem_to_reg #(.AW(16), .DW(32), .req_t(reg_req_t), .rsp_t(reg_rsp_t), .WrRsp(1'b1)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt1), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .wstrb_i(wstrb), .rdata_o(rd1), .rvalid_o(rv1), .rerror_o(re1),
    .wr_err_o(werr1), .wr_err_clr_i(clr), .reg_req_o(rq1), .reg_rsp_i(rsp)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction: grant, t_wait stalled cycles, ready, then the response cycle.
  task automatic run_txn(input logic t_we, input logic [15:0] t_addr, input logic [31:0] t_wdata,
                         input logic [3:0] t_wstrb, input int t_wait, input logic [31:0] t_rdata,
                         input logic t_err, input logic t_clr);
    reg_req_t exp_rq;
    exp_rq       = '0;
    exp_rq.valid = 1'b1;
    exp_rq.write = t_we;
    exp_rq.addr  = {16'h0000, t_addr};
    exp_rq.wdata = t_wdata;
    exp_rq.wstrb = t_wstrb;

    req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata; wstrb = t_wstrb; rsp = '0; clr = 1'b0;
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1} !== 2'b11) begin
      errors++; $display("FAIL txn_grant: got %b expected 11", {gnt0, gnt1});
    end
    next_cycle();
    // Scramble the memory side so only the registered copy can satisfy the bus checks
    req = 1'b0; we = 1'($urandom); addr = 16'($urandom); wdata = $urandom; wstrb = 4'($urandom);
    for (int k = 0; k <= t_wait; k++) begin
      rsp.ready = (k == t_wait);
      rsp.rdata = (k == t_wait) ? t_rdata : $urandom;
      rsp.error = (k == t_wait) ? t_err : 1'($urandom);
      clr       = (k == t_wait) ? t_clr : 1'b0;
      @(negedge clk);
      checks++;
      if (rq0 !== exp_rq || rq1 !== exp_rq) begin
        errors++; $display("FAIL txn_bus_req cyc %0d: got %h / %h expected %h", k, rq0, rq1, exp_rq);
      end
      checks++;
      if ({gnt0, gnt1, rv0, rv1} !== 4'b0000) begin
        errors++; $display("FAIL txn_busy_outputs cyc %0d: gnt/rvalid got %b expected 0000", k, {gnt0, gnt1, rv0, rv1});
      end
      next_cycle();
    end
    if (t_we && t_err) wr_err_exp = 1'b1;
    else if (t_clr)    wr_err_exp = 1'b0;
    rsp = '0; clr = 1'b0;
    @(negedge clk);
    checks++;
    if (rv0 !== ~t_we || rv1 !== 1'b1) begin
      errors++; $display("FAIL txn_rvalid: got %b%b expected %b1", rv0, rv1, ~t_we);
    end
    checks++;
    if (rd0 !== (t_we ? 32'h0 : t_rdata) || rd1 !== (t_we ? 32'h0 : t_rdata)) begin
      errors++; $display("FAIL txn_rdata: got %h / %h expected %h", rd0, rd1, t_we ? 32'h0 : t_rdata);
    end
    checks++;
    if (re0 !== t_err || re1 !== t_err) begin
      errors++; $display("FAIL txn_rerror: got %b%b expected %b", re0, re1, t_err);
    end
    checks++;
    if (werr0 !== wr_err_exp || werr1 !== 1'b0) begin
      errors++; $display("FAIL txn_wr_err: got %b%b expected %b0", werr0, werr1, wr_err_exp);
    end
    checks++;
    if ({gnt0, gnt1} !== 2'b11) begin
      errors++; $display("FAIL txn_done_grant: got %b expected 11", {gnt0, gnt1});
    end
    next_cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; we = 1'b0; clr = 1'b0; addr = '0; wdata = '0; wstrb = '0; rsp = '0;
    wr_err_exp = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({gnt0, gnt1, rv0, rv1, re0, re1, werr0, werr1} !== 8'b1100_0000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 11000000", {gnt0, gnt1, rv0, rv1, re0, re1, werr0, werr1});
    end
    checks++;
    if (rd0 !== 32'h0 || rd1 !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: got %h / %h expected 0", rd0, rd1);
    end
    checks++;
    if (rq0 !== '0 || rq1 !== '0) begin
      errors++; $display("FAIL reset_bus_req: got %h / %h expected 0", rq0, rq1);
    end
    next_cycle();
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_read_zero_wait();
    run_txn(1'b0, 16'h0010, 32'h0, 4'h0, 0, 32'hDEADBEEF, 1'b0, 1'b0);
  endtask

  task automatic test_read_stall();
    run_txn(1'b0, 16'h0044, 32'h0, 4'h0, 5, 32'hCAFEF00D, 1'b0, 1'b0);
  endtask

  task automatic test_write_no_rsp();
    run_txn(1'b1, 16'h0020, 32'h12345678, 4'hF, 0, 32'hA5A5A5A5, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (werr0 !== 1'b1 || rv0 !== 1'b0) begin
        errors++; $display("FAIL write_err_sticky: wr_err/rvalid got %b%b expected 10", werr0, rv0);
      end
      next_cycle();
    end
    clr = 1'b1;
    next_cycle();
    clr = 1'b0;
    wr_err_exp = 1'b0;
    @(negedge clk);
    checks++;
    if (werr0 !== 1'b0) begin
      errors++; $display("FAIL write_err_clear: got %b expected 0", werr0);
    end
    next_cycle();
  endtask

  task automatic test_collision();
    run_txn(1'b1, 16'h0100, 32'h0BADF00D, 4'h3, 1, 32'h0, 1'b1, 1'b0);
    run_txn(1'b1, 16'h0104, 32'h00C0FFEE, 4'hC, 0, 32'h0, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if (werr0 !== 1'b1) begin
      errors++; $display("FAIL collision_set_wins: got %b expected 1", werr0);
    end
    next_cycle();
    run_txn(1'b0, 16'h0108, 32'h0, 4'h0, 0, 32'h11112222, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] data [4];
    logic [15:0] adr  [4];
    for (int i = 0; i < 4; i++) begin
      data[i] = $urandom;
      adr[i]  = 16'($urandom);
    end
    rsp = '0;
    for (int i = 0; i < 4; i++) begin
      req = 1'b1; we = 1'b0; addr = adr[i]; wdata = $urandom; wstrb = 4'($urandom);
      rsp = '0;
      @(negedge clk);
      checks++;
      if (gnt0 !== 1'b1 || rv0 !== (i > 0)) begin
        errors++; $display("FAIL b2b_grant_rvalid %0d: got %b%b expected 1%b", i, gnt0, rv0, i > 0);
      end
      if (i > 0) begin
        checks++;
        if (rd0 !== data[i-1] || rd1 !== data[i-1]) begin
          errors++; $display("FAIL b2b_order %0d: got %h expected %h", i - 1, rd0, data[i-1]);
        end
      end
      next_cycle();
      rsp.ready = 1'b1; rsp.rdata = data[i]; rsp.error = 1'b0;
      @(negedge clk);
      checks++;
      if (gnt0 !== 1'b0 || rq0.valid !== 1'b1 || rq0.addr !== {16'h0, adr[i]}) begin
        errors++; $display("FAIL b2b_busy %0d: gnt/valid got %b%b addr %h expected 01 %h", i, gnt0, rq0.valid, rq0.addr, adr[i]);
      end
      next_cycle();
    end
    req = 1'b0; rsp = '0;
    @(negedge clk);
    checks++;
    if (rv0 !== 1'b1 || rd0 !== data[3]) begin
      errors++; $display("FAIL b2b_last: rvalid %b rdata %h expected 1 %h", rv0, rd0, data[3]);
    end
    next_cycle();
  endtask

  task automatic test_reset_busy();
    req = 1'b1; we = 1'b0; addr = 16'h0200; rsp = '0;
    next_cycle();
    req = 1'b0;
    @(negedge clk);
    checks++;
    if (rq0.valid !== 1'b1) begin
      errors++; $display("FAIL rst_busy_pre: valid got %b expected 1", rq0.valid);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (rq0 !== '0 || rq1 !== '0 || {gnt0, gnt1, rv0, rv1} !== 4'b1100) begin
      errors++; $display("FAIL rst_busy_async: req %h gnt/rvalid %b expected 0 1100", rq0, {gnt0, gnt1, rv0, rv1});
    end
    wr_err_exp = 1'b0;
    next_cycle();
    rst = 1'b0;
    rsp.ready = 1'b1; rsp.rdata = 32'hFFFF0000; rsp.error = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({rv0, rv1, rq0.valid, gnt0} !== 4'b0001 || rd0 !== 32'h0) begin
        errors++; $display("FAIL rst_busy_after %0d: rvalid/valid/gnt %b rdata %h expected 0001 0", i, {rv0, rv1, rq0.valid, gnt0}, rd0);
      end
      next_cycle();
    end
    rsp = '0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int gap;
      run_txn(1'($urandom), 16'($urandom), $urandom, 4'($urandom), int'($urandom_range(0, 3)),
              $urandom, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        req = 1'b0; clr = ($urandom_range(0, 4) == 0);
        rsp.ready = 1'($urandom); rsp.rdata = $urandom; rsp.error = 1'($urandom);
        @(negedge clk);
        checks++;
        if ({gnt0, rv0, rv1, rq0.valid} !== 4'b1000 || werr0 !== wr_err_exp) begin
          errors++; $display("FAIL rand_idle %0d: gnt/rvalid/valid %b wr_err %b expected 1000 %b", n, {gnt0, rv0, rv1, rq0.valid}, werr0, wr_err_exp);
        end
        next_cycle();
        if (clr) wr_err_exp = 1'b0;
        clr = 1'b0;
      end
      rsp = '0;
    end
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_read_stall();
    test_write_no_rsp();
    test_collision();
    test_back_to_back();
    test_reset_busy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
